// File: rtl/tinychip_pkg.sv
// Shared definitions for the tinychip program loader: FSM encoding,
// error codes and default memory geometry.
package tinychip_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned INSTR_W_DEF = 9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LO   = 3'd2,
    ST_HI   = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ZERO_LEN = 2'b01;
  localparam logic [1:0] ERR_BAD_HI   = 2'b10;
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: length, N lo/hi instruction pairs and an XOR
// checksum are written into instruction memory while the core is held.
module program_loader
  import tinychip_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               core_hold,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [ADDR_W-1:0]  loaded
);

  // Count width wide enough to compare the 8-bit length against the index
  localparam int unsigned CW = (ADDR_W > 8) ? ADDR_W : 8;

  state_t        state;
  logic [7:0]    len_r;
  logic [7:0]    lo_r;
  logic [7:0]    csum;
  logic [CW-1:0] next_cnt;
  logic          last_instr;
  logic          xfer;

  assign xfer = in_valid & in_ready;

  always_comb begin
    next_cnt   = CW'(loaded) + CW'(1);
    last_instr = (next_cnt == CW'(len_r));
  end

  always_comb begin
    in_ready  = (state == ST_LEN) || (state == ST_LO) ||
                (state == ST_HI)  || (state == ST_CHK);
    done      = (state == ST_DONE);
    err       = (state == ST_ERR);
    core_hold = (state != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      len_r    <= '0;
      lo_r     <= '0;
      csum     <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      err_code <= ERR_NONE;
      loaded   <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_LEN;
            err_code <= ERR_NONE;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            len_r  <= in_data;
            loaded <= '0;
            csum   <= in_data;
            if (in_data == 8'd0) begin
              state    <= ST_ERR;
              err_code <= ERR_ZERO_LEN;
            end else begin
              state <= ST_LO;
            end
          end
        end
        ST_LO: begin
          if (xfer) begin
            lo_r  <= in_data;
            csum  <= csum ^ in_data;
            state <= ST_HI;
          end
        end
        ST_HI: begin
          if (xfer) begin
            if (in_data[7:1] != 7'd0) begin
              state    <= ST_ERR;
              err_code <= ERR_BAD_HI;
            end else begin
              // loaded doubles as the write index; it advances with the strobe
              im_we    <= 1'b1;
              im_addr  <= loaded;
              im_wdata <= INSTR_W'({in_data[0], lo_r});
              loaded   <= loaded + 1'b1;
              csum     <= csum ^ in_data;
              state    <= last_instr ? ST_CHK : ST_LO;
            end
          end
        end
        ST_CHK: begin
          if (xfer) begin
            if (in_data == csum) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_ERR;
              err_code <= ERR_CHECKSUM;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
